// File: rtl/conv_stream_engine.sv
// conv_stream_engine
//   Streaming 2-D "valid" convolution. After START a FIL_S x FIL_S signed
//   filter is loaded in raster order. Then one DI_W x DI_H frame is accepted
//   as a raster pixel stream, and the (DI_W-FIL_S+1) x (DI_H-FIL_S+1) result
//   stream is produced through a single-entry output register with
//   valid/ready handshaking.
//
//   Optional feature: define CONV_RELU_EN to force negative results to zero
//   after saturation. Latency and handshake are the same with or without it.
//
// Ports
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   START               one-cycle pulse, honoured only while idle
//   FIL_VALID/READY/I   filter word stream, row 0 col 0 first
//   DI_VALID/READY/DI   input pixel stream, raster order
//   DO_VALID/READY/DO   output pixel stream, raster order
//   DO_LAST             marks the final output pixel of the frame
//   BUSY                high whenever the engine is not idle
module conv_stream_engine #(
    parameter int INWIDTH = 16,
    parameter int IN_FRAC = 12,
    parameter int DI_W    = 7,
    parameter int DI_H    = 7,
    parameter int FIL_S   = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               FIL_VALID,
    output logic               FIL_READY,
    input  logic [INWIDTH-1:0] FIL_I,
    input  logic               DI_VALID,
    output logic               DI_READY,
    input  logic [INWIDTH-1:0] DI,
    output logic               DO_VALID,
    input  logic               DO_READY,
    output logic [INWIDTH-1:0] DO,
    output logic               DO_LAST,
    output logic               BUSY
);

    localparam int NTAP  = FIL_S * FIL_S;
    localparam int ACC_W = 2 * INWIDTH + $clog2(NTAP);
    // Pixel history: the newest FIL_S-1 full rows plus FIL_S-1 pixels are
    // exactly the line buffers plus the window, kept as one shift chain.
    localparam int SR_LEN = (FIL_S == 1) ? 1 : (FIL_S - 1) * DI_W + FIL_S - 1;
    localparam int CW = $clog2(DI_W + 1);
    localparam int RW = $clog2(DI_H + 1);
    localparam int FW = $clog2(NTAP + 1);

    localparam logic [CW-1:0] COL_LAST  = CW'(DI_W - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(FIL_S - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(DI_H - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(FIL_S - 1);
    localparam logic [FW-1:0] FIL_LAST  = FW'(NTAP - 1);

    localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(64'sd1 <<< (IN_FRAC - 1));
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((64'sd1 <<< (INWIDTH - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]                state;
    logic [FW-1:0]             fil_cnt;
    logic [CW-1:0]             col;
    logic [RW-1:0]             row;
    logic signed [INWIDTH-1:0] filt [NTAP];
    logic signed [INWIDTH-1:0] sr   [SR_LEN];
    logic signed [INWIDTH-1:0] cur  [SR_LEN+1];
    logic signed [2*INWIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc;
    logic signed [INWIDTH-1:0] res;
    logic signed [INWIDTH-1:0] res_out;
    logic                      pix_fire;
    logic                      qualify;
    logic                      last_pix;

    // Round half up, arithmetic shift, then clamp to the output word range.
    function automatic logic signed [INWIDTH-1:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] t;
        t = {a[ACC_W-1], a} + HALF;
        t = t >>> IN_FRAC;
        if (t > SAT_MAX)
            return SAT_MAX[INWIDTH-1:0];
        else if (t < SAT_MIN)
            return SAT_MIN[INWIDTH-1:0];
        else
            return t[INWIDTH-1:0];
    endfunction

    assign FIL_READY = (state == S_LOAD);
    assign DI_READY  = (state == S_RUN) && (!DO_VALID || DO_READY);
    assign BUSY      = (state != S_IDLE);
    assign pix_fire  = DI_VALID && DI_READY;
    assign qualify   = (row >= ROW_FIRST) && (col >= COL_FIRST);
    assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);

    // Stage 0: window as it will look once the incoming pixel is shifted in.
    // cur[0] is the incoming pixel; cur[k] is the pixel k positions older.
    always_comb begin
        cur[0] = DI;
        for (int m = 1; m <= SR_LEN; m++)
            cur[m] = sr[m-1];
    end

    always_comb begin
        acc  = '0;
        prod = '0;
        for (int i = 0; i < FIL_S; i++) begin
            for (int j = 0; j < FIL_S; j++) begin
                prod = cur[(FIL_S-1-i)*DI_W + (FIL_S-1-j)] * filt[i*FIL_S + j];
                acc  = acc + ACC_W'(prod);
            end
        end
    end

    assign res = round_sat(acc);

`ifdef CONV_RELU_EN
    assign res_out = res[INWIDTH-1] ? '0 : res;
`else
    assign res_out = res;
`endif

    // Stage 1: control state, pixel history and the output register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            fil_cnt  <= '0;
            col      <= '0;
            row      <= '0;
            DO       <= '0;
            DO_VALID <= 1'b0;
            DO_LAST  <= 1'b0;
            for (int t = 0; t < NTAP; t++)
                filt[t] <= '0;
            for (int m = 0; m < SR_LEN; m++)
                sr[m] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state   <= S_LOAD;
                        fil_cnt <= '0;
                        col     <= '0;
                        row     <= '0;
                    end
                end
                S_LOAD: begin
                    if (FIL_VALID) begin
                        filt[fil_cnt] <= FIL_I;
                        if (fil_cnt == FIL_LAST) begin
                            fil_cnt <= '0;
                            state   <= S_RUN;
                        end else begin
                            fil_cnt <= fil_cnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (pix_fire) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row   <= '0;
                                state <= S_DRAIN;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (DO_VALID && DO_READY && DO_LAST)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (pix_fire) begin
                for (int m = 0; m < SR_LEN; m++)
                    sr[m] <= cur[m];
            end

            // A qualifying pixel reloads the register even while the current
            // word is being taken, giving one result per clock.
            if (pix_fire && qualify) begin
                DO       <= res_out;
                DO_VALID <= 1'b1;
                DO_LAST  <= last_pix;
            end else if (DO_READY) begin
                DO_VALID <= 1'b0;
                DO_LAST  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_stream_engine.sv
module tb_conv_stream_engine;

    localparam int NOUT = 25;
    localparam int NPIX = 49;

    logic        CLK = 1'b0;
    logic        RST, START, FIL_VALID, FIL_READY, DI_VALID, DI_READY;
    logic        DO_VALID, DO_READY, DO_LAST, BUSY;
    logic [15:0] FIL_I, DI, DO;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    conv_stream_engine dut (
        .CLK(CLK), .RST(RST), .START(START),
        .FIL_VALID(FIL_VALID), .FIL_READY(FIL_READY), .FIL_I(FIL_I),
        .DI_VALID(DI_VALID), .DI_READY(DI_READY), .DI(DI),
        .DO_VALID(DO_VALID), .DO_READY(DO_READY), .DO(DO),
        .DO_LAST(DO_LAST), .BUSY(BUSY)
    );

    // tap_idx 9 loads every tap with 'tap'; otherwise only that tap is set.
    // ramp pixels are r*7+c; expected = scale*DI(r+dr, c+dc). Otherwise the
    // pixels are constant 'pix' and every output is 'exp_val'.
    typedef struct {
        int          tap_idx;
        logic [15:0] tap;
        logic        ramp;
        logic [15:0] pix;
        logic        bp;
        logic [15:0] exp_val;
        int          scale;
        int          dr;
        int          dc;
    } vec_t;

    vec_t tab [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pixval(input vec_t v, input int r, input int c);
        return v.ramp ? 16'(r * 7 + c) : v.pix;
    endfunction

    function automatic logic [15:0] expval(input vec_t v, input int k);
        int r, c;
        r = k / 5;
        c = k % 5;
        return v.ramp ? 16'(v.scale * ((r + v.dr) * 7 + c + v.dc)) : v.exp_val;
    endfunction

    // Loads the filter and streams the frame; stop_after >= 0 abandons the
    // frame once that many pixels have been accepted. Returns at a negedge.
    task automatic run_frame(input vec_t v, input int stop_after);
        int          pix, outk, cyc;
        logic        stalled, di_fire, do_fire;
        logic [15:0] held;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("busy_after_start", BUSY, 1);
        check("fil_ready_in_load", FIL_READY, 1);
        // junk pixels offered during the load must be ignored
        DI_VALID = 1'b1;
        DI = 16'h7777;
        for (int t = 0; t < 9; t++) begin
            FIL_VALID = 1'b1;
            FIL_I = (v.tap_idx == 9 || v.tap_idx == t) ? v.tap : 16'h0000;
            @(negedge CLK);
        end
        // junk filter words offered while running must be ignored
        FIL_I = 16'h1234;
        check("fil_ready_in_run", FIL_READY, 0);
        pix = 0; outk = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (outk < NOUT && cyc < 2000 && !(stop_after >= 0 && pix >= stop_after)) begin
            DO_READY = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix < NPIX) begin
                DI_VALID = 1'b1;
                DI = pixval(v, pix / 7, pix % 7);
            end else begin
                DI_VALID = 1'b0;
                DI = 16'hDEAD;
            end
            START = (pix == 5);
            #1;
            if (stalled) begin
                check("stall_valid_held", DO_VALID, 1);
                check("stall_data_held", DO, held);
            end
            if (DO_VALID && !DO_READY)
                check("di_ready_low_in_stall", DI_READY, 0);
            di_fire = DI_VALID && DI_READY;
            do_fire = DO_VALID && DO_READY;
            if (do_fire) begin
                check($sformatf("do_data[%0d]", outk), DO, expval(v, outk));
                check($sformatf("do_last[%0d]", outk), DO_LAST, (outk == NOUT - 1));
                outk++;
            end
            stalled = DO_VALID && !DO_READY;
            held = DO;
            if (di_fire)
                pix++;
            @(negedge CLK);
            cyc++;
        end
        START = 1'b0;
        DI_VALID = 1'b0;
        FIL_VALID = 1'b0;
        DO_READY = 1'b1;
        if (cyc >= 2000) begin
            errors++;
            checks++;
            $display("FAIL frame_timeout: got %0d outputs expected %0d", outk, NOUT);
        end
        if (stop_after < 0) begin
            check("pixels_consumed", pix, NPIX);
            check("idle_after_last", BUSY, 0);
            check("valid_low_after_last", DO_VALID, 0);
        end
    endtask

    initial begin
        tab[0]  = '{tap_idx:4, tap:16'h1000, ramp:1, pix:0, bp:0, exp_val:0, scale:1, dr:1, dc:1};
        tab[1]  = '{tap_idx:4, tap:16'h1000, ramp:1, pix:0, bp:1, exp_val:0, scale:1, dr:1, dc:1};
        tab[2]  = '{tap_idx:0, tap:16'h1000, ramp:1, pix:0, bp:0, exp_val:0, scale:1, dr:0, dc:0};
        tab[3]  = '{tap_idx:7, tap:16'h1000, ramp:1, pix:0, bp:1, exp_val:0, scale:1, dr:2, dc:1};
        tab[4]  = '{tap_idx:4, tap:16'h2000, ramp:1, pix:0, bp:1, exp_val:0, scale:2, dr:1, dc:1};
        tab[5]  = '{tap_idx:9, tap:16'h1000, ramp:0, pix:16'h1000, bp:0, exp_val:16'h7FFF, scale:0, dr:0, dc:0};
        tab[6]  = '{tap_idx:9, tap:16'h1000, ramp:0, pix:16'hF000, bp:1, exp_val:16'h8000, scale:0, dr:0, dc:0};
        tab[7]  = '{tap_idx:4, tap:16'h0800, ramp:0, pix:16'h0001, bp:0, exp_val:16'h0001, scale:0, dr:0, dc:0};
        tab[8]  = '{tap_idx:4, tap:16'h0800, ramp:0, pix:16'hFFFF, bp:0, exp_val:16'h0000, scale:0, dr:0, dc:0};
        tab[9]  = '{tap_idx:4, tap:16'h0C00, ramp:0, pix:16'h0003, bp:1, exp_val:16'h0002, scale:0, dr:0, dc:0};
        tab[10] = '{tap_idx:4, tap:16'h0800, ramp:0, pix:16'hFFFA, bp:0, exp_val:16'hFFFD, scale:0, dr:0, dc:0};

        RST = 1'b1; START = 1'b0; FIL_VALID = 1'b0; FIL_I = '0;
        DI_VALID = 1'b0; DI = '0; DO_READY = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_busy", BUSY, 0);
        check("rst_fil_ready", FIL_READY, 0);
        check("rst_di_ready", DI_READY, 0);
        check("rst_do_valid", DO_VALID, 0);
        check("rst_do", DO, 0);
        check("rst_do_last", DO_LAST, 0);
        RST = 1'b0;
        // START is a no-op until idle; pulse it in idle only via run_frame

        for (int n = 0; n < 11; n++)
            run_frame(tab[n], -1);

        // negative result: passes through, or clamps to zero with ReLU
        begin
            vec_t rv;
`ifdef CONV_RELU_EN
            rv = '{tap_idx:4, tap:16'hF000, ramp:0, pix:16'h1000, bp:0, exp_val:16'h0000, scale:0, dr:0, dc:0};
`else
            rv = '{tap_idx:4, tap:16'hF000, ramp:0, pix:16'h1000, bp:0, exp_val:16'hF000, scale:0, dr:0, dc:0};
`endif
            run_frame(rv, -1);
        end

        // abort mid-frame after 20 accepted pixels, then run a clean frame
        run_frame(tab[1], 20);
        DO_READY = 1'b0;
        RST = 1'b1;
        #1;
        check("abort_busy", BUSY, 0);
        check("abort_do_valid", DO_VALID, 0);
        check("abort_do", DO, 0);
        check("abort_do_last", DO_LAST, 0);
        check("abort_di_ready", DI_READY, 0);
        check("abort_fil_ready", FIL_READY, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        DO_READY = 1'b1;
        @(negedge CLK);
        check("post_abort_idle_valid", DO_VALID, 0);
        check("post_abort_idle_busy", BUSY, 0);
        run_frame(tab[0], -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
